rv_imem_loader: RTL and testbench

- UART-driven instruction-memory writer; the write-side counterpart to the program counter's fetch (read) side of IMEM.
- Accepts a framed byte stream from the UART receiver and assembles little-endian 32-bit words.
- Writes those words into IMEM at byte addresses 0,4,8,…, matching the program counter's byte addressing.
- Holds the core halted for the whole load, then requests a core reset so execution restarts from address 0.

---
 rtl/rv_soc_pkg.sv | 27 ++
 rtl/rv_loader_timeout.sv | 37 +++
 rtl/rv_imem_loader.sv | 222 ++++++++++++++++++++++
 tb/tb_rv_imem_loader.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_soc_pkg.sv
// Shared loader definitions: FSM state encoding, frame sync marker, error codes.
// Pure declarations, no logic; imported by the loader and its timeout counter.
// No flow control of its own.
package rv_soc_pkg;

    typedef enum logic [2:0] {
        S_SYNC = 3'd0,
        S_LEN0 = 3'd1,
        S_LEN1 = 3'd2,
        S_DATA = 3'd3,
        S_CSUM = 3'd4,
        S_DONE = 3'd5
    } ld_state_t;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    localparam logic [1:0] ERR_NONE = 2'b00;
    localparam logic [1:0] ERR_LEN  = 2'b01;
    localparam logic [1:0] ERR_TMO  = 2'b10;
    localparam logic [1:0] ERR_CSUM = 2'b11;

    // States in which a silent UART means the sender has stalled mid-frame.
    function automatic logic tmo_active(input ld_state_t s);
        return (s == S_LEN0) || (s == S_LEN1) || (s == S_DATA) || (s == S_CSUM);
    endfunction

endpackage

// File: rtl/rv_loader_timeout.sv
// Idle watchdog: counts enabled cycles since the last clear; expire pulses on the TIMEOUT_CYC-th.
// Latency: expire is combinational from the count, the counter reloads to zero the same edge.
// No backpressure; clr has priority over counting.
module rv_loader_timeout #(
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic clr,
    input  logic en,
    output logic expire
);
    import rv_soc_pkg::*;

    localparam int            CW   = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        expire = en && !clr && (cnt_q == LAST);
        cnt_d  = cnt_q + CW'(1);
        if (clr || !en || expire) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/rv_imem_loader.sv
// UART frame -> IMEM word writer that halts the core during load; RV_IMEM_LOADER_CHECKSUM_EN adds a trailing XOR byte.
// Latency: every output is registered, one cycle after the byte that causes it.
// No backpressure: rx_valid strobes are consumed unconditionally, one byte per strobe.
module rv_imem_loader #(
    parameter int         DEPTH_WORDS   = 1024,
    parameter int         TIMEOUT_CYC   = 100000,
    parameter bit         HALT_AT_RESET = 1'b1,
    parameter logic [7:0] SYNC_BYTE     = rv_soc_pkg::SYNC_BYTE
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        cpu_hlt,
    output logic        core_rst_req,
    output logic        load_done,
    output logic        load_err,
    output logic [1:0]  err_code
);
    import rv_soc_pkg::*;

    localparam int          WIDX_W  = $clog2(DEPTH_WORDS + 1);
    localparam logic [16:0] LEN_MAX = 17'(DEPTH_WORDS);

`ifdef RV_IMEM_LOADER_CHECKSUM_EN
    localparam ld_state_t S_TAIL = S_CSUM;
`else
    localparam ld_state_t S_TAIL = S_DONE;
`endif

    ld_state_t         state_q, state_d;
    logic [7:0]        len_lo_q, len_lo_d;
    logic [15:0]       len_q, len_d;
    logic [WIDX_W-1:0] word_idx_q, word_idx_d;
    logic [1:0]        byte_idx_q, byte_idx_d;
    logic [23:0]       wbuf_q, wbuf_d;
`ifdef RV_IMEM_LOADER_CHECKSUM_EN
    logic [7:0]        csum_q, csum_d;
`endif

    logic        imem_we_q, imem_we_d;
    logic [31:0] imem_addr_q, imem_addr_d;
    logic [31:0] imem_wdata_q, imem_wdata_d;
    logic        cpu_hlt_q, cpu_hlt_d;
    logic        core_rst_req_q, core_rst_req_d;
    logic        load_done_q, load_done_d;
    logic        load_err_q, load_err_d;
    logic [1:0]  err_code_q, err_code_d;

    logic [15:0] len_rx;
    logic        last_word;
    logic        tmo_en;
    logic        tmo_expire;

    assign len_rx    = {rx_data, len_lo_q};
    assign last_word = (16'(word_idx_q) == (len_q - 16'd1));
    assign tmo_en    = tmo_active(state_q);

    rv_loader_timeout #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_tmo (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .clr       (rx_valid),
        .en        (tmo_en),
        .expire    (tmo_expire)
    );

    always_comb begin
        state_d      = state_q;
        len_lo_d     = len_lo_q;
        len_d        = len_q;
        word_idx_d   = word_idx_q;
        byte_idx_d   = byte_idx_q;
        wbuf_d       = wbuf_q;
`ifdef RV_IMEM_LOADER_CHECKSUM_EN
        csum_d       = csum_q;
`endif
        imem_we_d    = 1'b0;
        imem_addr_d  = imem_addr_q;
        imem_wdata_d = imem_wdata_q;
        cpu_hlt_d    = cpu_hlt_q;
        load_err_d   = 1'b0;
        err_code_d   = err_code_q;

        case (state_q)
            S_LEN0: begin
                if (rx_valid) begin
                    len_lo_d = rx_data;
                    state_d  = S_LEN1;
                end
            end
            S_LEN1: begin
                if (rx_valid) begin
                    len_d = len_rx;
                    if ({1'b0, len_rx} > LEN_MAX) begin
                        load_err_d = 1'b1;
                        err_code_d = ERR_LEN;
                        state_d    = S_SYNC;
                    end else if (len_rx == 16'd0) begin
                        state_d = S_TAIL;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                // A sync-valued byte here is payload, never a restart.
                if (rx_valid) begin
                    byte_idx_d = byte_idx_q + 2'd1;
`ifdef RV_IMEM_LOADER_CHECKSUM_EN
                    csum_d     = csum_q ^ rx_data;
`endif
                    if (byte_idx_q == 2'd3) begin
                        imem_we_d    = 1'b1;
                        imem_addr_d  = 32'(word_idx_q) << 2;
                        imem_wdata_d = {rx_data, wbuf_q};
                        word_idx_d   = word_idx_q + WIDX_W'(1);
                        if (last_word) begin
                            state_d = S_TAIL;
                        end
                    end else begin
                        wbuf_d = {rx_data, wbuf_q[23:8]};
                    end
                end
            end
`ifdef RV_IMEM_LOADER_CHECKSUM_EN
            S_CSUM: begin
                if (rx_valid) begin
                    if (rx_data == csum_q) begin
                        state_d = S_DONE;
                    end else begin
                        load_err_d = 1'b1;
                        err_code_d = ERR_CSUM;
                        state_d    = S_SYNC;
                    end
                end
            end
`endif
            default: begin
                // S_SYNC, and S_DONE whose incoming byte is judged exactly as in S_SYNC.
                if (state_q == S_DONE) begin
                    cpu_hlt_d = 1'b0;
                end
                state_d = S_SYNC;
                if (rx_valid && (rx_data == SYNC_BYTE)) begin
                    cpu_hlt_d  = 1'b1;
                    err_code_d = ERR_NONE;
                    word_idx_d = '0;
                    byte_idx_d = '0;
`ifdef RV_IMEM_LOADER_CHECKSUM_EN
                    csum_d     = 8'd0;
`endif
                    state_d    = S_LEN0;
                end
            end
        endcase

        if (tmo_expire) begin
            load_err_d = 1'b1;
            err_code_d = ERR_TMO;
            state_d    = S_SYNC;
        end

        // S_DONE lasts one cycle, so it is only ever the next state on entry.
        load_done_d    = (state_d == S_DONE);
        core_rst_req_d = load_done_d;
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q        <= S_SYNC;
            len_lo_q       <= 8'd0;
            len_q          <= 16'd0;
            word_idx_q     <= '0;
            byte_idx_q     <= 2'd0;
            wbuf_q         <= 24'd0;
`ifdef RV_IMEM_LOADER_CHECKSUM_EN
            csum_q         <= 8'd0;
`endif
            imem_we_q      <= 1'b0;
            imem_addr_q    <= 32'd0;
            imem_wdata_q   <= 32'd0;
            cpu_hlt_q      <= HALT_AT_RESET;
            core_rst_req_q <= 1'b0;
            load_done_q    <= 1'b0;
            load_err_q     <= 1'b0;
            err_code_q     <= ERR_NONE;
        end else begin
            state_q        <= state_d;
            len_lo_q       <= len_lo_d;
            len_q          <= len_d;
            word_idx_q     <= word_idx_d;
            byte_idx_q     <= byte_idx_d;
            wbuf_q         <= wbuf_d;
`ifdef RV_IMEM_LOADER_CHECKSUM_EN
            csum_q         <= csum_d;
`endif
            imem_we_q      <= imem_we_d;
            imem_addr_q    <= imem_addr_d;
            imem_wdata_q   <= imem_wdata_d;
            cpu_hlt_q      <= cpu_hlt_d;
            core_rst_req_q <= core_rst_req_d;
            load_done_q    <= load_done_d;
            load_err_q     <= load_err_d;
            err_code_q     <= err_code_d;
        end
    end

    assign imem_we      = imem_we_q;
    assign imem_addr    = imem_addr_q;
    assign imem_wdata   = imem_wdata_q;
    assign cpu_hlt      = cpu_hlt_q;
    assign core_rst_req = core_rst_req_q;
    assign load_done    = load_done_q;
    assign load_err     = load_err_q;
    assign err_code     = err_code_q;

endmodule

// File: tb/tb_rv_imem_loader.sv
// Bench for rv_imem_loader: directed frames from the load procedure plus random frames,
// each checked against a frame-level model of which words land where and how the load ends.
module tb_rv_imem_loader;

    localparam int DEPTH = 1024;
    localparam int TMO   = 100;
`ifdef RV_IMEM_LOADER_CHECKSUM_EN
    localparam bit CSUM_EN = 1'b1;
`else
    localparam bit CSUM_EN = 1'b0;
`endif

    logic        sys_clk   = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic [7:0]  rx_data   = 8'd0;
    logic        rx_valid  = 1'b0;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        cpu_hlt;
    logic        core_rst_req;
    logic        load_done;
    logic        load_err;
    logic [1:0]  err_code;

    always #5 sys_clk = ~sys_clk;

    rv_imem_loader #(
        .DEPTH_WORDS   (DEPTH),
        .TIMEOUT_CYC   (TMO),
        .HALT_AT_RESET (1'b1),
        .SYNC_BYTE     (8'hA5)
    ) dut (
        .sys_clk      (sys_clk),
        .sys_rst_n    (sys_rst_n),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .imem_we      (imem_we),
        .imem_addr    (imem_addr),
        .imem_wdata   (imem_wdata),
        .cpu_hlt      (cpu_hlt),
        .core_rst_req (core_rst_req),
        .load_done    (load_done),
        .load_err     (load_err),
        .err_code     (err_code)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // Output monitor, sampled on the falling edge.
    logic [31:0] wr_addr[$];
    logic [31:0] wr_data[$];
    int   n_done  = 0;
    int   n_err   = 0;
    int   n_rreq  = 0;
    int   n_split = 0;
    bit   done_prev = 1'b0;
    logic hlt_after = 1'b1;

    always @(negedge sys_clk) begin
        if (sys_rst_n) begin
            if (imem_we) begin
                wr_addr.push_back(imem_addr);
                wr_data.push_back(imem_wdata);
            end
            if (load_done) n_done++;
            if (load_err) n_err++;
            if (core_rst_req) n_rreq++;
            if (load_done != core_rst_req) n_split++;
            if (done_prev) hlt_after = cpu_hlt;
            done_prev = load_done;
        end
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge sys_clk);
        #1;
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
        repeat (gap) begin
            @(posedge sys_clk);
            #1;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge sys_clk);
            #1;
        end
    endtask

    logic [31:0] pay[$];
    logic [7:0]  pre[$];

    // Sends pre[], then a frame of len words taken from pay[], and checks the outcome.
    task automatic run_frame(input string tag, input int len, input bit bad_csum, input int gap_max);
        int          base = wr_addr.size();
        int          d0 = n_done;
        int          e0 = n_err;
        int          r0 = n_rreq;
        int          nwr;
        logic [15:0] l16 = len[15:0];
        logic [7:0]  cs = 8'd0;
        bit          ovf = (len > DEPTH);
        bit          bad = bad_csum && CSUM_EN && !ovf;
        bit          ok;
        logic [1:0]  exp_code;
        foreach (pre[i]) send_byte(pre[i], $urandom_range(0, gap_max));
        send_byte(8'hA5, $urandom_range(0, gap_max));
        send_byte(l16[7:0], $urandom_range(0, gap_max));
        send_byte(l16[15:8], $urandom_range(0, gap_max));
        if (!ovf) begin
            for (int w = 0; w < len; w++) begin
                for (int b = 0; b < 4; b++) begin
                    logic [7:0] by;
                    by = pay[w][8*b +: 8];
                    cs ^= by;
                    send_byte(by, $urandom_range(0, gap_max));
                end
            end
            if (CSUM_EN) send_byte(bad_csum ? cs + 8'd1 : cs, 0);
        end
        idle(4);
        ok       = !ovf && !bad;
        exp_code = ovf ? 2'b01 : (bad ? 2'b11 : 2'b00);
        nwr      = wr_addr.size() - base;
        chk({tag, ".nwr"}, nwr, ovf ? 0 : len);
        for (int w = 0; w < nwr && w < len && !ovf; w++) begin
            chk($sformatf("%s.addr%0d", tag, w), wr_addr[base+w], 32'(w * 4));
            chk($sformatf("%s.data%0d", tag, w), wr_data[base+w], pay[w]);
        end
        chk({tag, ".done"}, n_done - d0, ok ? 1 : 0);
        chk({tag, ".rreq"}, n_rreq - r0, ok ? 1 : 0);
        chk({tag, ".err"}, n_err - e0, ok ? 0 : 1);
        chk({tag, ".code"}, err_code, exp_code);
        chk({tag, ".hlt"}, cpu_hlt, ok ? 1'b0 : 1'b1);
        if (ok) chk({tag, ".hlt_after_done"}, hlt_after, 1'b0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, checks so far %0d", n_chk);
        $fatal(1);
    end

    initial begin
        int k;
        int base;
        int e0;
        logic [7:0] b;

        sys_rst_n = 1'b0;
        idle(3);
        chk("rst.hlt", cpu_hlt, 1'b1);
        chk("rst.we", imem_we, 1'b0);
        chk("rst.addr", imem_addr, 32'd0);
        chk("rst.wdata", imem_wdata, 32'd0);
        chk("rst.done", load_done, 1'b0);
        chk("rst.rreq", core_rst_req, 1'b0);
        chk("rst.err", load_err, 1'b0);
        chk("rst.code", err_code, 2'b00);
        sys_rst_n = 1'b1;
        idle(2);

        pay = '{32'h0000_0013, 32'h0010_0093};
        pre = {};
        run_frame("basic", 2, 1'b0, 0);

        run_frame("ovf", 1025, 1'b0, 0);

        // Stall mid-frame: A5 01 00 11 22 then silence.
        base = wr_addr.size();
        e0   = n_err;
        send_byte(8'hA5, 0);
        send_byte(8'h01, 0);
        send_byte(8'h00, 0);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        k = 0;
        while (k < 300 && !load_err) begin
            @(posedge sys_clk);
            #1;
            k++;
        end
        chk("tmo.latency", k, TMO);
        chk("tmo.code", err_code, 2'b10);
        chk("tmo.hlt", cpu_hlt, 1'b1);
        idle(2);
        chk("tmo.err", n_err - e0, 1);
        chk("tmo.nwr", wr_addr.size() - base, 0);
        pay = '{$urandom};
        run_frame("tmo.recover", 1, 1'b0, 2);

        pre = '{8'h00, 8'hFF};
        run_frame("len0", 0, 1'b0, 1);
        pre = {};

        pay = '{32'hDEAD_BEEF};
        run_frame("csum_bad", 1, 1'b1, 0);

        // Reset after the 2nd payload byte of a frame following a good load.
        pay = '{$urandom, $urandom};
        run_frame("pre_rst", 2, 1'b0, 0);
        base = wr_addr.size();
        send_byte(8'hA5, 0);
        send_byte(8'h02, 0);
        send_byte(8'h00, 0);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        sys_rst_n = 1'b0;
        #1;
        chk("midrst.hlt", cpu_hlt, 1'b1);
        chk("midrst.addr", imem_addr, 32'd0);
        chk("midrst.wdata", imem_wdata, 32'd0);
        chk("midrst.we", imem_we, 1'b0);
        idle(2);
        sys_rst_n = 1'b1;
        idle(1);
        send_byte(8'h33, 0);
        send_byte(8'h44, 0);
        idle(3);
        chk("midrst.nwr", wr_addr.size() - base, 0);
        pay = '{$urandom, $urandom, $urandom};
        run_frame("post_rst", 3, 1'b0, 1);

        for (int it = 0; it < 20; it++) begin
            int len;
            len = ($urandom_range(0, 9) == 0) ? 1025 + $urandom_range(0, 50) : $urandom_range(0, 5);
            pay = {};
            for (int w = 0; w < 6; w++) begin
                logic [31:0] wd;
                wd = $urandom;
                if ($urandom_range(0, 5) == 0) wd[7:0] = 8'hA5;
                pay.push_back(wd);
            end
            pre = {};
            repeat ($urandom_range(0, 2)) begin
                b = 8'($urandom);
                if (b == 8'hA5) b = 8'h5A;
                pre.push_back(b);
            end
            run_frame($sformatf("rnd%0d", it), len, ($urandom_range(0, 3) == 0), 3);
        end
        pre = {};

        chk("done_rreq_together", n_split, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
